ps2_keyboard_rx: RTL and testbench

Receives PS/2 keyboard frames on the ps2_clock/ps2_data pins and validates parity and the stop bit. Buffers good scancode bytes in a small show-ahead FIFO. Sits upstream of the display path: the top level pops scancodes to drive the `number` register shown on the seven-segment scanner and LEDs, replacing the free-running demo counter. Runs entirely in the 100 MHz clk_in domain and oversamples the slow device clock.

---
 rtl/ps2_keyboard_rx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the device clock, decodes
// 11-bit frames with odd-parity/stop checks, and queues good scancodes in a show-ahead FIFO.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk_in,
  input  logic                          reset_btn,
  input  logic                          ps2_clock,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_clk_q, filt_clk_d;
  logic          fall_q;
  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          push_q, perr_q, ferr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          valid_q, ovf_q, ovf_d;
  logic          do_pop_s, do_push_s, full_s, timeout_s;

  // Clock filter: the level flips only after FILTER_LEN consecutive disagreeing cycles.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    filt_clk_d = filt_clk_q;
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_clk_d = ~filt_clk_q;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end else begin
      filt_cnt_d = '0;
    end
  end

  // Pin synchronizers, filter state and the registered fall strobe.
  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_cnt_q <= '0;
      filt_clk_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clock};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      filt_cnt_q <= filt_cnt_d;
      filt_clk_q <= filt_clk_d;
      fall_q     <= filt_clk_q & ~filt_clk_d;
    end
  end

  assign timeout_s = (state_q != IDLE) && !fall_q && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Frame decoder FSM with inter-edge timeout; error and push strobes are registered.
  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      push_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      if (fall_q || state_q == IDLE) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (fall_q && !dat_sync_q[1]) begin
            state_q   <= DATA;
            bit_cnt_q <= 3'd0;
          end
        end
        DATA: begin
          if (fall_q) begin
            shift_q   <= {dat_sync_q[1], shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
        end
        PARITY: begin
          if (fall_q) begin
            par_q   <= dat_sync_q[1];
            state_q <= STOP;
          end
        end
        STOP: begin
          if (fall_q) begin
            perr_q  <= ~odd_parity_ok(shift_q, par_q);
            ferr_q  <= ~dat_sync_q[1];
            push_q  <= odd_parity_ok(shift_q, par_q) & dat_sync_q[1];
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (timeout_s) begin
        state_q <= IDLE;
        ferr_q  <= 1'b1;
      end
    end
  end

  // FIFO next-state; a push at full is accepted only when a pop frees a slot that cycle.
  always_comb begin
    full_s    = (count_q == CW'(FIFO_DEPTH));
    do_pop_s  = rd_en && (count_q != '0);
    do_push_s = push_q && (!full_s || do_pop_s);
    ovf_d     = ovf_q | (push_q & full_s & ~do_pop_s);
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    head_d    = 8'h00;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (count_d == '0) begin
      head_d = 8'h00;
    end else if (do_push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = shift_q;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage, pointers and registered head/status outputs.
  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 8'h00;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= shift_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
      ovf_q    <= ovf_d;
    end
  end

  assign rd_data    = head_q;
  assign rd_valid   = valid_q;
  assign fifo_count = count_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed frames plus random frames
// checked against a queue-based scancode FIFO model.
module tb_ps2_keyboard_rx;
  localparam int FL = 8;
  localparam int TO = 1000;
  localparam int D  = 4;

  logic       clk_in = 1'b0;
  logic       reset_btn, ps2_clock, ps2_data, rd_en;
  logic [7:0] rd_data;
  logic       rd_valid, parity_err, frame_err, overflow;
  logic [2:0] fifo_count;

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(D)) dut (
    .clk_in(clk_in), .reset_btn(reset_btn), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] q[$];
  bit         m_ovf;
  int         n_assert = 0, n_fail = 0;
  int         perr_cnt = 0, ferr_cnt = 0;
  int         pb, fb;

  // Error strobes are counted in high cycles, so a 1 per frame also proves 1-cycle width.
  always @(negedge clk_in) begin
    if (parity_err) perr_cnt++;
    if (frame_err)  ferr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() < D) q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic model_pop();
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic check_fifo(input string tag);
    chk({tag, ".valid"}, 32'(rd_valid), 32'(q.size() != 0));
    chk({tag, ".data"},  32'(rd_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
  endtask

  task automatic check_err(input string tag, input int ep, input int ef);
    chk({tag, ".perr"}, 32'(perr_cnt - pb), 32'(ep));
    chk({tag, ".ferr"}, 32'(ferr_cnt - fb), 32'(ef));
  endtask

  // gbit: bit index whose high phase carries a 3-cycle low glitch; pop_on_push pulses
  // rd_en so it lands in the cycle the stop-bit push is expected.
  task automatic send_frame(input logic [7:0] b, input bit flip, input bit stopv,
                            input int half, input int nbits, input int gbit,
                            input bit pop_on_push);
    logic [10:0] bits;
    bits = {stopv, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == gbit) begin
        wait_cyc(10); ps2_clock = 1'b0; wait_cyc(3); ps2_clock = 1'b1; wait_cyc(half - 13);
      end else begin
        wait_cyc(half);
      end
      ps2_clock = 1'b0;
      if (pop_on_push && i == 10) begin
        wait_cyc(11); rd_en = 1'b1; wait_cyc(1); rd_en = 1'b0; wait_cyc(half - 12);
      end else begin
        wait_cyc(half);
      end
      ps2_clock = 1'b1;
    end
    wait_cyc(half);
    ps2_data = 1'b1;
  endtask

  task automatic frame_and_check(input string tag, input logic [7:0] b, input bit flip,
                                 input bit stopv, input int half);
    bit pok;
    pb = perr_cnt; fb = ferr_cnt;
    send_frame(b, flip, stopv, half, 11, -1, 1'b0);
    wait_cyc(20);
    pok = !flip;
    if (pok && stopv) model_push(b);
    check_err(tag, pok ? 0 : 1, stopv ? 0 : 1);
    check_fifo(tag);
  endtask

  task automatic pop_and_check(input string tag);
    rd_en = 1'b1; wait_cyc(1); rd_en = 1'b0;
    model_pop();
    wait_cyc(1);
    check_fifo(tag);
  endtask

  task automatic do_reset();
    reset_btn = 1'b1; wait_cyc(3); reset_btn = 1'b0;
    q.delete(); m_ovf = 1'b0;
    wait_cyc(1);
  endtask

  initial begin
    ps2_clock = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; m_ovf = 1'b0;
    do_reset();
    check_fifo("reset");
    chk("reset.perr", 32'(parity_err), 32'h0);
    chk("reset.ferr", 32'(frame_err), 32'h0);

    frame_and_check("valid1c", 8'h1C, 1'b0, 1'b1, 20);
    pop_and_check("valid1c.pop");

    frame_and_check("b2b_f0", 8'hF0, 1'b0, 1'b1, 18);
    frame_and_check("b2b_1c", 8'h1C, 1'b0, 1'b1, 18);
    pop_and_check("b2b.pop1");
    pop_and_check("b2b.pop2");
    pop_and_check("empty.pop");

    frame_and_check("badpar", 8'h1C, 1'b1, 1'b1, 20);
    frame_and_check("after_badpar", 8'h32, 1'b0, 1'b1, 20);
    pop_and_check("after_badpar.pop");

    pb = perr_cnt; fb = ferr_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 20, 5, -1, 1'b0);
    wait_cyc(TO + 500);
    check_err("trunc", 0, 1);
    check_fifo("trunc");
    frame_and_check("after_trunc", 8'h32, 1'b0, 1'b1, 20);
    pop_and_check("after_trunc.pop");

    for (int i = 1; i <= 5; i++) frame_and_check("ovf_fill", 8'(i), 1'b0, 1'b1, 16);
    pop_and_check("ovf.pop");
    frame_and_check("ovf_refill", 8'h06, 1'b0, 1'b1, 16);
    pb = perr_cnt; fb = ferr_cnt;
    send_frame(8'h07, 1'b0, 1'b1, 20, 11, -1, 1'b1);
    model_pop(); model_push(8'h07);
    wait_cyc(20);
    check_err("full_push_pop", 0, 0);
    check_fifo("full_push_pop");
    for (int i = 0; i < 5; i++) pop_and_check("drain");

    pb = perr_cnt; fb = ferr_cnt;
    ps2_clock = 1'b0; wait_cyc(3); ps2_clock = 1'b1; wait_cyc(20);
    send_frame(8'h1C, 1'b0, 1'b1, 20, 11, 4, 1'b0);
    model_push(8'h1C);
    wait_cyc(20);
    check_err("glitch", 0, 0);
    check_fifo("glitch");

    frame_and_check("pre_reset", 8'h55, 1'b0, 1'b1, 20);
    send_frame(8'h1C, 1'b0, 1'b1, 20, 6, -1, 1'b0);
    do_reset();
    check_fifo("midreset");
    chk("midreset.perr", 32'(parity_err), 32'h0);
    chk("midreset.ferr", 32'(frame_err), 32'h0);
    frame_and_check("post_reset", 8'h1C, 1'b0, 1'b1, 20);

    for (int n = 0; n < 24; n++) begin
      int kind, pops;
      kind = $urandom_range(0, 5);
      frame_and_check("rand", 8'($urandom), kind == 3 || kind == 5, !(kind == 4 || kind == 5),
                      $urandom_range(16, 30));
      pops = $urandom_range(0, 2);
      for (int p = 0; p < pops; p++) pop_and_check("rand.pop");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
